// File: rtl/ctrl_core_lim.sv
// ctrl_core_lim: top-level controller of a bin-oriented SAT core.
// Sequences BCP -> DECISION / ANALYSIS -> BKT loops, counts conflicts against
// an optional budget and reports SAT / UNSAT / ABORT for the loaded bin.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   start_core_i, kill_i   run start (ignored while busy), abandon run
//   conflict_limit_i       conflict budget, 0 = unlimited
//   cur_bin_num_i          id of the loaded bin
//   start_*_o / done_*_i   one-cycle start pulses and completion strobes for
//                          the imply, decision, analyze and backtrack engines
//   conflict_i, all_c_is_sat_i, bkt_bin_num_i  engine status
//   busy_o, done_core_o    run in progress, one-cycle completion pulse
//   result_o               0 none, 1 SAT, 2 UNSAT, 3 ABORT
//   conflict_cnt_o         conflicts counted in the current run
//
// Optional feature: define CTRL_CORE_LIM_STATS_EN to add decision_cnt_o and
// cycle_cnt_o (32-bit saturating run statistics).
module ctrl_core_lim #(
   parameter int WIDTH_BIN_ID = 10,
   parameter int WIDTH_LVL    = 16,
   parameter int WIDTH_CNT    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_core_i,
   input  logic                    kill_i,
   input  logic [WIDTH_CNT-1:0]    conflict_limit_i,
   input  logic [WIDTH_BIN_ID-1:0] cur_bin_num_i,
   output logic                    start_imply_o,
   input  logic                    done_imply_i,
   input  logic                    conflict_i,
   output logic                    start_decision_o,
   input  logic                    done_decision_i,
   input  logic                    all_c_is_sat_i,
   output logic                    start_analyze_o,
   input  logic                    done_analyze_i,
   input  logic [WIDTH_BIN_ID-1:0] bkt_bin_num_i,
   output logic                    start_bkt_o,
   input  logic                    done_bkt_i,
   output logic                    busy_o,
   output logic                    done_core_o,
   output logic [1:0]              result_o,
   output logic [WIDTH_CNT-1:0]    conflict_cnt_o
`ifdef CTRL_CORE_LIM_STATS_EN
   ,
   output logic [31:0]             decision_cnt_o,
   output logic [31:0]             cycle_cnt_o
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_BCP, S_DECISION, S_ANALYSIS, S_BKT, S_FINISH
   } state_t;

   localparam logic [1:0] RES_NONE  = 2'd0;
   localparam logic [1:0] RES_SAT   = 2'd1;
   localparam logic [1:0] RES_UNSAT = 2'd2;
   localparam logic [1:0] RES_ABORT = 2'd3;

   // Decision levels are tracked by the engines, not here; the width is kept
   // for interface compatibility with the rest of the core.
   if (WIDTH_LVL < 1) begin : g_lvl_width_invalid
   end

   state_t                 state_q, state_d;
   logic [1:0]             result_q, result_d;
   logic [WIDTH_CNT-1:0]   cnt_q, cnt_d;
   logic [WIDTH_CNT-1:0]   cnt_inc;
   logic                   exhausted;
   // High in the first cycle after any state change; qualifies start pulses.
   logic                   first_q, first_d;
   logic                   kill_run;

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      exhausted = (conflict_limit_i != '0) && (cnt_inc == conflict_limit_i);
      kill_run  = kill_i && (state_q != S_IDLE);

      unique case (state_q)
         S_IDLE: if (start_core_i) begin
            state_d  = S_BCP;
            cnt_d    = '0;
            result_d = RES_NONE;
         end
         S_BCP: if (done_imply_i) begin
            // Conflict wins over all-satisfied.
            if (conflict_i) begin
               cnt_d = cnt_inc;
               if (exhausted) begin
                  state_d  = S_FINISH;
                  result_d = RES_ABORT;
               end else begin
                  state_d = S_ANALYSIS;
               end
            end else if (all_c_is_sat_i) begin
               state_d  = S_FINISH;
               result_d = RES_SAT;
            end else begin
               state_d = S_DECISION;
            end
         end
         S_DECISION: if (done_decision_i) begin
            if (all_c_is_sat_i) begin
               state_d  = S_FINISH;
               result_d = RES_SAT;
            end else begin
               state_d = S_BCP;
            end
         end
         S_ANALYSIS: if (done_analyze_i) begin
            if (bkt_bin_num_i == cur_bin_num_i) begin
               state_d = S_BKT;
            end else begin
               state_d  = S_FINISH;
               result_d = RES_UNSAT;
            end
         end
         S_BKT: if (done_bkt_i) state_d = S_DECISION;
         S_FINISH: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Kill discards whatever the done inputs would have done this cycle.
      if (kill_run) begin
         state_d  = S_IDLE;
         result_d = result_q;
         cnt_d    = cnt_q;
      end

      first_d = (state_d != state_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         result_q <= RES_NONE;
         cnt_q    <= '0;
         first_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         first_q  <= first_d;
      end
   end

   assign start_imply_o    = first_q && (state_q == S_BCP);
   assign start_decision_o = first_q && (state_q == S_DECISION);
   assign start_analyze_o  = first_q && (state_q == S_ANALYSIS);
   assign start_bkt_o      = first_q && (state_q == S_BKT);
   assign busy_o           = (state_q != S_IDLE);
   assign done_core_o      = (state_q == S_FINISH);
   assign result_o         = result_q;
   assign conflict_cnt_o   = cnt_q;

`ifdef CTRL_CORE_LIM_STATS_EN
   logic [31:0] dec_cnt_q, dec_cnt_d;
   logic [31:0] cyc_cnt_q, cyc_cnt_d;

   always_comb begin
      dec_cnt_d = dec_cnt_q;
      cyc_cnt_d = cyc_cnt_q;
      if (state_q == S_IDLE && start_core_i) begin
         dec_cnt_d = '0;
         cyc_cnt_d = '0;
      end else begin
         if (state_q == S_DECISION && done_decision_i && !kill_run &&
             dec_cnt_q != '1)
            dec_cnt_d = dec_cnt_q + 32'd1;
         if (busy_o && cyc_cnt_q != '1)
            cyc_cnt_d = cyc_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dec_cnt_q <= '0;
         cyc_cnt_q <= '0;
      end else begin
         dec_cnt_q <= dec_cnt_d;
         cyc_cnt_q <= cyc_cnt_d;
      end
   end

   assign decision_cnt_o = dec_cnt_q;
   assign cycle_cnt_o    = cyc_cnt_q;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ctrl_core_lim.sv
// Scoreboard bench for ctrl_core_lim. The driver pushes the expected
// {result, conflict count} of each run that must complete; the monitor pops
// and compares on every done_core_o. The counter is built 4 bits wide so
// saturation is reached within a short run.
module tb_ctrl_core_lim;
   localparam int BW = 10;
   localparam int LW = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_core_i, kill_i;
   logic [CW-1:0] conflict_limit_i;
   logic [BW-1:0] cur_bin_num_i, bkt_bin_num_i;
   logic          start_imply_o, done_imply_i, conflict_i;
   logic          start_decision_o, done_decision_i, all_c_is_sat_i;
   logic          start_analyze_o, done_analyze_i;
   logic          start_bkt_o, done_bkt_i;
   logic          busy_o, done_core_o;
   logic [1:0]    result_o;
   logic [CW-1:0] conflict_cnt_o;

   always #5 clk = ~clk;

   ctrl_core_lim #(.WIDTH_BIN_ID(BW), .WIDTH_LVL(LW), .WIDTH_CNT(CW)) dut (
      .clk(clk), .rst(rst), .start_core_i(start_core_i), .kill_i(kill_i),
      .conflict_limit_i(conflict_limit_i), .cur_bin_num_i(cur_bin_num_i),
      .start_imply_o(start_imply_o), .done_imply_i(done_imply_i),
      .conflict_i(conflict_i), .start_decision_o(start_decision_o),
      .done_decision_i(done_decision_i), .all_c_is_sat_i(all_c_is_sat_i),
      .start_analyze_o(start_analyze_o), .done_analyze_i(done_analyze_i),
      .bkt_bin_num_i(bkt_bin_num_i), .start_bkt_o(start_bkt_o),
      .done_bkt_i(done_bkt_i), .busy_o(busy_o), .done_core_o(done_core_o),
      .result_o(result_o), .conflict_cnt_o(conflict_cnt_o));

   typedef struct {
      logic [1:0]    res;
      logic [CW-1:0] cnt;
   } exp_t;
   exp_t sbq[$];

   int checks = 0, errors = 0;
   int n_imp = 0, n_dec = 0, n_ana = 0, n_bkt = 0, n_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pulse counters, done pulse width, scoreboard compare.
   initial begin
      bit   prev_done;
      exp_t e;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         n_imp  += int'(start_imply_o);
         n_dec  += int'(start_decision_o);
         n_ana  += int'(start_analyze_o);
         n_bkt  += int'(start_bkt_o);
         n_done += int'(done_core_o);
         if (prev_done) chk("done_pulse_width", 32'(done_core_o), 32'd0);
         if (done_core_o) begin
            if (sbq.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("sb_result", 32'(result_o), 32'(e.res));
               chk("sb_conflict_cnt", 32'(conflict_cnt_o), 32'(e.cnt));
            end
         end
         prev_done = done_core_o;
      end
   end

   function automatic bit sel(input int w);
      case (w)
         0: return start_imply_o;
         1: return start_decision_o;
         2: return start_analyze_o;
         3: return start_bkt_o;
         default: return done_core_o;
      endcase
   endfunction

   // Returns at a negedge where the selected output is high, or after a bounded wait.
   task automatic wait_sig(input int w, input string name);
      for (int i = 0; i < 100; i++) begin
         if (sel(w)) return;
         @(negedge clk);
      end
      chk({"timeout_", name}, 32'd0, 32'd1);
   endtask

   task automatic start_run(input logic [CW-1:0] lim);
      conflict_limit_i = lim;
      start_core_i = 1'b1;
      @(negedge clk);
      start_core_i = 1'b0;
   endtask

   task automatic do_imply(input logic c, input logic s);
      wait_sig(0, "imply");
      done_imply_i = 1'b1; conflict_i = c; all_c_is_sat_i = s;
      @(negedge clk);
      done_imply_i = 1'b0; conflict_i = 1'b0; all_c_is_sat_i = 1'b0;
   endtask

   task automatic do_decision(input logic s);
      wait_sig(1, "decision");
      done_decision_i = 1'b1; all_c_is_sat_i = s;
      @(negedge clk);
      done_decision_i = 1'b0; all_c_is_sat_i = 1'b0;
   endtask

   task automatic do_analyze(input logic [BW-1:0] b);
      wait_sig(2, "analyze");
      done_analyze_i = 1'b1; bkt_bin_num_i = b;
      @(negedge clk);
      done_analyze_i = 1'b0;
   endtask

   task automatic do_bkt();
      wait_sig(3, "bkt");
      done_bkt_i = 1'b1;
      @(negedge clk);
      done_bkt_i = 1'b0;
   endtask

   task automatic finish_wait();
      wait_sig(4, "done_core");
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int a0, b0, d0;
      rst = 1'b1; start_core_i = 0; kill_i = 0; conflict_limit_i = '0;
      cur_bin_num_i = 10'd5; bkt_bin_num_i = '0; done_imply_i = 0; conflict_i = 0;
      done_decision_i = 0; all_c_is_sat_i = 0; done_analyze_i = 0; done_bkt_i = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_result", 32'(result_o), 0);
      chk("rst_cnt", 32'(conflict_cnt_o), 0);
      chk("rst_starts", 32'({start_imply_o, start_decision_o, start_analyze_o, start_bkt_o}), 0);
      chk("rst_done", 32'(done_core_o), 0);
      rst = 1'b0;
      @(negedge clk);

      // Immediate SAT from BCP.
      sbq.push_back('{2'd1, 4'd0});
      start_run(4'd0);
      do_imply(1'b0, 1'b1);
      finish_wait();
      chk("sat_result_hold", 32'(result_o), 1);
      chk("sat_idle", 32'(busy_o), 0);

      // Budget of 3 conflicts: the third aborts without analysis.
      a0 = n_ana; b0 = n_bkt;
      sbq.push_back('{2'd3, 4'd3});
      start_run(4'd3);
      for (int i = 0; i < 2; i++) begin
         do_imply(1'b1, 1'b0);
         do_analyze(10'd5);
         do_bkt();
         do_decision(1'b0);
      end
      do_imply(1'b1, 1'b0);
      finish_wait();
      chk("abort_analyze_pulses", 32'(n_ana - a0), 2);
      chk("abort_bkt_pulses", 32'(n_bkt - b0), 2);
      chk("abort_cnt_hold", 32'(conflict_cnt_o), 3);

      // Backtrack leaves the bin -> UNSAT, no backtrack started.
      b0 = n_bkt;
      sbq.push_back('{2'd2, 4'd1});
      start_run(4'd0);
      do_imply(1'b1, 1'b0);
      do_analyze(10'd4);
      finish_wait();
      chk("unsat_no_bkt", 32'(n_bkt - b0), 0);

      // Conflict and all-satisfied together: conflict wins.
      a0 = n_ana;
      sbq.push_back('{2'd1, 4'd1});
      start_run(4'd0);
      do_imply(1'b1, 1'b1);
      do_analyze(10'd5);
      do_bkt();
      do_decision(1'b1);
      finish_wait();
      chk("prio_analyze_pulses", 32'(n_ana - a0), 1);

      // Kill together with done_decision, then immediate restart.
      d0 = n_done;
      start_run(4'd0);
      do_imply(1'b0, 1'b0);
      wait_sig(1, "decision");
      done_decision_i = 1'b1; all_c_is_sat_i = 1'b1; kill_i = 1'b1;
      @(negedge clk);
      done_decision_i = 1'b0; all_c_is_sat_i = 1'b0; kill_i = 1'b0;
      chk("kill_idle", 32'(busy_o), 0);
      chk("kill_result", 32'(result_o), 0);
      sbq.push_back('{2'd1, 4'd0});
      start_run(4'd0);
      chk("kill_no_done", 32'(n_done - d0), 0);
      chk("restart_busy", 32'(busy_o), 1);
      chk("restart_imply", 32'(start_imply_o), 1);
      do_imply(1'b0, 1'b1);
      finish_wait();

      // Limit lowered mid-run; a start during the run is ignored.
      sbq.push_back('{2'd3, 4'd2});
      start_run(4'd5);
      do_imply(1'b1, 1'b0);
      do_analyze(10'd5);
      do_bkt();
      wait_sig(1, "decision");
      start_core_i = 1'b1; conflict_limit_i = 4'd2;
      @(negedge clk);
      start_core_i = 1'b0;
      done_decision_i = 1'b1;
      @(negedge clk);
      done_decision_i = 1'b0;
      do_imply(1'b1, 1'b0);
      finish_wait();

      // Reset mid-run behaves like kill and clears the counter.
      d0 = n_done;
      start_run(4'd0);
      do_imply(1'b1, 1'b0);
      chk("pre_rst_cnt", 32'(conflict_cnt_o), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", 32'(busy_o), 0);
      chk("midrst_cnt", 32'(conflict_cnt_o), 0);
      chk("midrst_result", 32'(result_o), 0);
      @(negedge clk);
      chk("midrst_no_done", 32'(n_done - d0), 0);

      // Unlimited budget: counter saturates at all-ones, never aborts.
      sbq.push_back('{2'd2, 4'd15});
      start_run(4'd0);
      for (int i = 0; i < 20; i++) begin
         do_imply(1'b1, 1'b0);
         if (i == 19) begin
            do_analyze(10'd4);
         end else begin
            do_analyze(10'd5);
            do_bkt();
            do_decision(1'b0);
         end
      end
      finish_wait();

      chk("sb_drained", 32'(sbq.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ctrl_core_lim.md
CTRL_CORE_LIM -- requirements
Module: ctrl_core_lim

Interface
REQ-001 Parameter WIDTH_BIN_ID, default 10: bin identifier width.
REQ-002 Parameter WIDTH_LVL, default 16: decision level and bin count width.
REQ-003 Parameter WIDTH_CNT, default 16: conflict counter and limit width.
REQ-004 Ports SHALL be as follows; one clock; reset is synchronous and active-high.
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- start_core_i, input, 1: start solving the loaded bin.
- kill_i, input, 1: abandon the current run.
- conflict_limit_i, input, WIDTH_CNT: conflict budget; 0 means unlimited.
- cur_bin_num_i, input, WIDTH_BIN_ID: id of the loaded bin.
- start_imply_o, output, 1: BCP start pulse.
- done_imply_i, input, 1: BCP finished.
- conflict_i, input, 1: BCP found a conflict; qualified by done_imply_i.
- start_decision_o, output, 1: decision start pulse.
- done_decision_i, input, 1: decision finished.
- all_c_is_sat_i, input, 1: all clauses are satisfied.
- start_analyze_o, output, 1: conflict analysis start pulse.
- done_analyze_i, input, 1: analysis finished.
- bkt_bin_num_i, input, WIDTH_BIN_ID: backtrack target bin.
- start_bkt_o, output, 1: in-bin backtrack start pulse.
- done_bkt_i, input, 1: backtrack finished.
- busy_o, output, 1: engine is running.
- done_core_o, output, 1: one-cycle completion pulse.
- result_o, output, 2: 0 none, 1 SAT, 2 UNSAT (backtrack leaves the bin), 3 ABORT (conflict budget exhausted).
- conflict_cnt_o, output, WIDTH_CNT: conflicts counted in the current run.

Function
REQ-005 States SHALL be IDLE, BCP, DECISION, ANALYSIS, BKT, FINISH; the state is registered.
REQ-006 IDLE -> BCP on start_core_i; the conflict counter clears and result_o clears to 0 on the same edge.
REQ-007 BCP transitions on done_imply_i:
- conflict_i with the budget exhausted -> FINISH, result 3.
- conflict_i otherwise -> ANALYSIS.
- no conflict and all_c_is_sat_i -> FINISH, result 1.
- no conflict otherwise -> DECISION.
REQ-008 Conflict takes priority over all_c_is_sat_i when both are asserted in the same cycle.
REQ-009 Conflict counting:
- conflict_cnt_o increments by 1 on each done_imply_i with conflict_i in BCP.
- The budget is exhausted when conflict_limit_i != 0 and the incremented count equals conflict_limit_i.
- The counter saturates at all-ones.
REQ-010 DECISION transitions on done_decision_i: to FINISH with result 1 if all_c_is_sat_i, else to BCP.
REQ-011 ANALYSIS transitions on done_analyze_i: to BKT if bkt_bin_num_i == cur_bin_num_i, else to FINISH with result 2.
REQ-012 BKT -> DECISION on done_bkt_i.
REQ-013 FINISH -> IDLE after exactly one cycle; done_core_o is high during that FINISH cycle only.
REQ-014 Each start_*_o SHALL be high for exactly one cycle: the first cycle spent in its state on each entry, including re-entry via BCP->DECISION->BCP loops.
REQ-015 A done_*_i input is ignored unless the FSM is in the matching state; a done in the same cycle as its start pulse is accepted.
REQ-016 result_o holds its value from FINISH until the next accepted start_core_i.
REQ-017 busy_o is high in every state except IDLE.
REQ-018 start_core_i is ignored while busy_o is high.
REQ-019 kill_i in any non-IDLE state forces IDLE on the next edge:
- no done_core_o pulse is produced;
- result_o is left at 0;
- no start pulse is issued;
- kill_i overrides every simultaneous done input.
REQ-020 conflict_limit_i is sampled continuously; a change mid-run takes effect at the next conflict.

Reset
REQ-021 When rst is high at a clock edge:
- state goes to IDLE;
- all start_*_o, done_core_o and busy_o go to 0;
- result_o goes to 0 and conflict_cnt_o goes to 0.
REQ-022 Reset mid-run SHALL behave like kill_i, with the counter also cleared.

Configuration
REQ-023 With macro CTRL_CORE_LIM_STATS_EN defined, the block adds these outputs, all cleared on start_core_i and reset:
- decision_cnt_o, 32 bits: count of done_decision_i accepted in DECISION.
- cycle_cnt_o, 32 bits: cycles with busy_o high.
- Both counters saturate at all-ones.
REQ-024 Without CTRL_CORE_LIM_STATS_EN, those ports and counters SHALL be absent, and all other behaviour is identical.

Verification
REQ-025 Scenario: start, BCP done with no conflict and all_c_is_sat_i=1 -> FINISH next cycle, done_core_o one cycle, result_o=1, conflict_cnt_o=0.
REQ-026 Scenario: limit=3, cur_bin=5, three BCP conflicts each analysed with bkt_bin=5 and backtracked -> third conflict goes straight to FINISH, result_o=3, conflict_cnt_o=3, only two start_analyze_o pulses seen.
REQ-027 Scenario: conflict, analysis returns bkt_bin=4 with cur_bin=5 -> result_o=2, no start_bkt_o pulse.
REQ-028 Scenario: done_imply_i with conflict_i=1 and all_c_is_sat_i=1 in the same cycle -> ANALYSIS entered and start_analyze_o pulses.
REQ-029 Scenario: kill_i asserted in DECISION together with done_decision_i -> IDLE, no done_core_o, result_o=0; a new start_core_i is accepted one cycle later.
REQ-030 Scenario: limit=0 with 70000 conflicts and WIDTH_CNT=16 -> no ABORT, conflict_cnt_o saturates at 65535.
